// File: rtl/jt12_chacc_if.sv
// Slot-stream bus into the channel accumulator and its channel/mix results.
// The master drives the operator slot stream; the slave (accumulator) returns
// per-channel results and the per-frame left/right mix.
interface jt12_chacc_if #(
    parameter int MIX_W = 12
);
    logic                    zero;
    logic                    s1_enters;
    logic                    s3_enters;
    logic                    s2_enters;
    logic                    s4_enters;
    logic [2:0]              alg;
    logic [1:0]              rl;
    logic signed [8:0]       op_result;
    logic                    en_dac;
    logic signed [8:0]       dac_val;
    logic signed [8:0]       ch_out;
    logic [2:0]              ch_idx;
    logic                    ch_valid;
    logic signed [MIX_W-1:0] left;
    logic signed [MIX_W-1:0] right;
    logic                    sample;

    modport master (
        output zero, s1_enters, s3_enters, s2_enters, s4_enters,
        output alg, rl, op_result, en_dac, dac_val,
        input  ch_out, ch_idx, ch_valid, left, right, sample
    );

    modport slave (
        input  zero, s1_enters, s3_enters, s2_enters, s4_enters,
        input  alg, rl, op_result, en_dac, dac_val,
        output ch_out, ch_idx, ch_valid, left, right, sample
    );
endinterface

// File: rtl/jt12_chacc.sv
// Channel accumulator: sums carrier operators per channel from the
// time-multiplexed operator stream (S1,S3,S2,S4 groups x 6 channels), clips
// to 9 bits, applies the ch5 DAC override and L/R panning, and produces one
// left/right mix per 24-slot frame.
module jt12_chacc #(
    parameter int NUM_CH = 6,
    parameter int MIX_W  = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    jt12_chacc_if.slave  bus
);
    localparam int SUM_W = 12;
    localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);
    localparam logic signed [SUM_W-1:0] CLIP_HI = 12'sd255;
    localparam logic signed [SUM_W-1:0] CLIP_LO = -12'sd256;

    genvar gi;

    // channel tracking
    logic [2:0] ch_reg;
    logic [2:0] ch_cur;
    logic [2:0] ch_next;
    logic       last_ch;
    logic       synced_reg;
    logic       synced_now;

    // partial-sum store: stage 0 takes the new sum, the last stage is the
    // sum left by the same channel six slots ago
    logic signed [SUM_W-1:0] sum_reg [NUM_CH];
    logic signed [SUM_W-1:0] sum_in  [NUM_CH];
    logic signed [SUM_W-1:0] sum_head;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] op_ext;
    logic signed [SUM_W-1:0] op_carrier;
    logic signed [SUM_W-1:0] final_sum;
    logic                    carrier;

    // channel value and mix
    logic signed [8:0]       clip_val;
    logic signed [8:0]       chan_val;
    logic signed [MIX_W-1:0] chan_ext;
    logic signed [MIX_W-1:0] add_l;
    logic signed [MIX_W-1:0] add_r;
    logic signed [MIX_W-1:0] mix_l_sum;
    logic signed [MIX_W-1:0] mix_r_sum;
    logic signed [MIX_W-1:0] mix_l_reg;
    logic signed [MIX_W-1:0] mix_r_reg;

    // registered outputs
    logic signed [8:0]       ch_out_reg;
    logic [2:0]              ch_idx_reg;
    logic                    ch_valid_reg;
    logic signed [MIX_W-1:0] left_reg;
    logic signed [MIX_W-1:0] right_reg;
    logic                    sample_reg;

    // Current channel: zero re-aligns the counter to ch0 in its own slot.
    // The zero slot also counts as synced so the frame it starts is emitted.
    always_comb begin
        ch_cur     = bus.zero ? 3'd0 : ch_reg;
        ch_next    = (ch_cur >= CH_LAST) ? 3'd0 : ch_cur + 3'd1;
        last_ch    = (ch_cur == CH_LAST);
        synced_now = synced_reg | bus.zero;
    end

    // Carrier mask: a higher algorithm number promotes more operators to carriers.
    always_comb begin
        carrier = 1'b0;
        if (bus.s4_enters)      carrier = 1'b1;
        else if (bus.s2_enters) carrier = (bus.alg >= 3'd4);
        else if (bus.s3_enters) carrier = (bus.alg >= 3'd5);
        else if (bus.s1_enters) carrier = (bus.alg == 3'd7);
    end

    // Partial-sum update and final clip. Four 9-bit terms fit in 12 bits, so
    // the accumulation never wraps before the clip.
    always_comb begin
        sum_head   = sum_reg[NUM_CH-1];
        op_ext     = {{(SUM_W-9){bus.op_result[8]}}, bus.op_result};
        op_carrier = carrier ? op_ext : '0;
        final_sum  = sum_head + op_ext;

        if (bus.s1_enters)                        sum_next = op_carrier;
        else if (bus.s3_enters || bus.s2_enters) sum_next = sum_head + op_carrier;
        else if (bus.s4_enters)                   sum_next = '0;
        else                                      sum_next = sum_head;

        if (final_sum > CLIP_HI)      clip_val = 9'sd255;
        else if (final_sum < CLIP_LO) clip_val = -9'sd256;
        else                          clip_val = final_sum[8:0];

        chan_val = (bus.en_dac && last_ch) ? bus.dac_val : clip_val;
        chan_ext = {{(MIX_W-9){chan_val[8]}}, chan_val};
        add_l    = bus.rl[1] ? chan_ext : '0;
        add_r    = bus.rl[0] ? chan_ext : '0;
        // zero starts a fresh mix so a partial frame after reset cannot leak in
        mix_l_sum = (bus.zero ? '0 : mix_l_reg) + add_l;
        mix_r_sum = (bus.zero ? '0 : mix_r_reg) + add_r;
    end

    // Shift-register wiring: new sum enters stage 0, every other stage takes its predecessor.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sum
            if (gi == 0) begin : g_first
                assign sum_in[gi] = sum_next;
            end else begin : g_rest
                assign sum_in[gi] = sum_reg[gi-1];
            end
        end
    endgenerate

    // Partial-sum shift register, advancing one stage per enabled slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) sum_reg[i] <= '0;
        end else if (clk_en) begin
            for (int i = 0; i < NUM_CH; i++) sum_reg[i] <= sum_in[i];
        end
    end

    // Channel counter, sync flag, mix accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg       <= '0;
            synced_reg   <= 1'b0;
            mix_l_reg    <= '0;
            mix_r_reg    <= '0;
            ch_out_reg   <= '0;
            ch_idx_reg   <= '0;
            ch_valid_reg <= 1'b0;
            left_reg     <= '0;
            right_reg    <= '0;
            sample_reg   <= 1'b0;
        end else if (clk_en) begin
            ch_reg       <= ch_next;
            ch_valid_reg <= 1'b0;
            sample_reg   <= 1'b0;
            if (bus.zero) synced_reg <= 1'b1;

            if (bus.s4_enters) begin
                if (synced_now) begin
                    ch_out_reg   <= chan_val;
                    ch_idx_reg   <= ch_cur;
                    ch_valid_reg <= 1'b1;
                end
                if (last_ch) begin
                    mix_l_reg <= '0;
                    mix_r_reg <= '0;
                    if (synced_now) begin
                        left_reg   <= mix_l_sum;
                        right_reg  <= mix_r_sum;
                        sample_reg <= 1'b1;
                    end
                end else begin
                    mix_l_reg <= mix_l_sum;
                    mix_r_reg <= mix_r_sum;
                end
            end else if (bus.zero) begin
                mix_l_reg <= '0;
                mix_r_reg <= '0;
            end
        end
    end

    assign bus.ch_out   = ch_out_reg;
    assign bus.ch_idx   = ch_idx_reg;
    assign bus.ch_valid = ch_valid_reg;
    assign bus.left     = left_reg;
    assign bus.right    = right_reg;
    assign bus.sample   = sample_reg;
endmodule
